// File: rtl/nexys_semseg_pkg.sv
// Shared 7-segment helpers for the Nexys board wrappers.
// Segment encoding is {ca,cb,cc,cd,ce,cf,cg}, active-low.
package nexys_semseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    function automatic logic [6:0] hex2semseg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h01;
            4'h1:    seg = 7'h4F;
            4'h2:    seg = 7'h12;
            4'h3:    seg = 7'h06;
            4'h4:    seg = 7'h4C;
            4'h5:    seg = 7'h24;
            4'h6:    seg = 7'h20;
            4'h7:    seg = 7'h0F;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h04;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h60;
            4'hC:    seg = 7'h31;
            4'hD:    seg = 7'h42;
            4'hE:    seg = 7'h30;
            4'hF:    seg = 7'h38;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/nexys_semseg_timebase.sv
// Digit-slot timebase: cycle counter within a slot, digit index, and the
// end-of-scan pulse on the last cycle of digit 7.
module nexys_semseg_timebase #(
    parameter int DIGIT_PERIOD = 1024,
    parameter int CNT_W        = $clog2(DIGIT_PERIOD)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [2:0]       idx_o,
    output logic             frame_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             wrap_s;

    // Next counter state; the 3-bit index wraps 7 -> 0 by itself.
    always_comb begin
        wrap_s = (cnt_q == CNT_LAST);
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        if (wrap_s) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign idx_o   = idx_q;
    assign frame_o = wrap_s && (idx_q == 3'd7);

endmodule

// File: rtl/nexys_semseg_scan_ctrl.sv
// 8-digit multiplexed 7-segment driver with a frame-synchronous double buffer,
// per-digit enable, decimal points and leading-zero suppression.
module nexys_semseg_scan_ctrl_chk #(
    parameter int DIGIT_PERIOD = 1024,
    parameter int DEAD_CYCLES  = 16
) ();
    if (DIGIT_PERIOD < 2) begin : g_bad_period
        $error("DIGIT_PERIOD must be at least 2");
    end
    if (DEAD_CYCLES >= DIGIT_PERIOD) begin : g_bad_dead
        $error("DEAD_CYCLES must be smaller than DIGIT_PERIOD");
    end
endmodule

module nexys_semseg_scan_ctrl
    import nexys_semseg_pkg::*;
#(
    parameter int DIGIT_PERIOD = 1024,
    parameter int DEAD_CYCLES  = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] data_i,
    input  logic [7:0]  dot_i,
    input  logic [7:0]  digit_en_i,
    input  logic        lzs_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        frame_o,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);

    localparam int               CNT_W  = $clog2(DIGIT_PERIOD);
    localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD_CYCLES);

    nexys_semseg_scan_ctrl_chk #(
        .DIGIT_PERIOD(DIGIT_PERIOD),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_chk ();

    logic [CNT_W-1:0] cnt_s;
    logic [2:0]       idx_s;
    logic             frame_s;

    nexys_semseg_timebase #(
        .DIGIT_PERIOD(DIGIT_PERIOD),
        .CNT_W       (CNT_W)
    ) u_timebase (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .cnt_o  (cnt_s),
        .idx_o  (idx_s),
        .frame_o(frame_s)
    );

    logic [31:0] pend_data_q, pend_data_d, disp_data_q, disp_data_d;
    logic [7:0]  pend_dot_q, pend_dot_d, disp_dot_q, disp_dot_d;
    logic [7:0]  pend_en_q, pend_en_d, disp_en_q, disp_en_d;
    logic        pend_lzs_q, pend_lzs_d, disp_lzs_q, disp_lzs_d;
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic        capture_s, apply_s, blank_s;
    logic [31:0] shifted_s;

    // Handshake and double buffer: the display word only changes at a frame edge,
    // and a capture in the frame cycle itself waits for the following edge.
    always_comb begin
        capture_s   = valid_i && !pend_vld_q;
        apply_s     = frame_s && pend_vld_q;
        pend_data_d = pend_data_q;
        pend_dot_d  = pend_dot_q;
        pend_en_d   = pend_en_q;
        pend_lzs_d  = pend_lzs_q;
        pend_vld_d  = pend_vld_q;
        disp_data_d = disp_data_q;
        disp_dot_d  = disp_dot_q;
        disp_en_d   = disp_en_q;
        disp_lzs_d  = disp_lzs_q;
        if (capture_s) begin
            pend_data_d = data_i;
            pend_dot_d  = dot_i;
            pend_en_d   = digit_en_i;
            pend_lzs_d  = lzs_i;
            pend_vld_d  = 1'b1;
        end else if (apply_s) begin
            disp_data_d = pend_data_q;
            disp_dot_d  = pend_dot_q;
            disp_en_d   = pend_en_q;
            disp_lzs_d  = pend_lzs_q;
            pend_vld_d  = 1'b0;
        end else begin
            pend_vld_d  = pend_vld_q;
        end
    end

    // Blanking and segment decode for the digit currently in its slot.
    always_comb begin
        shifted_s = disp_data_q >> {idx_s, 2'b00};
        blank_s   = (cnt_s < DEAD_C) || !disp_en_q[idx_s] ||
                    (disp_lzs_q && (idx_s != 3'd0) && (shifted_s == 32'd0));
        if (blank_s) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(8'h01 << idx_s);
            seg_d = hex2semseg(shifted_s[3:0]);
            dp_d  = ~disp_dot_q[idx_s];
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pend_data_q <= 32'd0;
            pend_dot_q  <= 8'd0;
            pend_en_q   <= 8'd0;
            pend_lzs_q  <= 1'b0;
            pend_vld_q  <= 1'b0;
            disp_data_q <= 32'd0;
            disp_dot_q  <= 8'd0;
            disp_en_q   <= 8'd0;
            disp_lzs_q  <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            pend_data_q <= pend_data_d;
            pend_dot_q  <= pend_dot_d;
            pend_en_q   <= pend_en_d;
            pend_lzs_q  <= pend_lzs_d;
            pend_vld_q  <= pend_vld_d;
            disp_data_q <= disp_data_d;
            disp_dot_q  <= disp_dot_d;
            disp_en_q   <= disp_en_d;
            disp_lzs_q  <= disp_lzs_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign ready_o = ~pend_vld_q;
    assign frame_o = frame_s;
    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;

endmodule
